// File: rtl/bist_pattern_controller.sv
// BIST sequencer: LFSR patterns drive a combinational CUT, responses fold into a MISR, final signature checked.
// Optional BIST_SIG_OUT_EN exposes the live MISR value on port sig.
module bist_pattern_controller #(
  parameter int                 NUM_PI     = 5,
  parameter int                 NUM_PO     = 2,
  parameter int                 MISR_W     = 8,
  parameter int                 PAT_CNT    = 32,
  parameter int                 SETTLE_CYC = 1,
  parameter logic [NUM_PI-1:0]  LFSR_SEED  = 5'h1F,
  parameter logic [NUM_PI-1:0]  LFSR_TAPS  = 5'h14,
  parameter logic [MISR_W-1:0]  MISR_TAPS  = 8'hB8,
  parameter logic [MISR_W-1:0]  GOLDEN_SIG = 8'h00
) (
  input  logic                           CK,
  input  logic                           RST,
  input  logic                           start,
  input  logic                           abort,
  output logic [NUM_PI-1:0]              cut_pi,
  input  logic [NUM_PO-1:0]              cut_po,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [$clog2(PAT_CNT+1)-1:0]   pat_idx
`ifdef BIST_SIG_OUT_EN
  ,
  output logic [MISR_W-1:0]              sig
`endif
);

  localparam int IDX_W = $clog2(PAT_CNT+1);
  localparam int CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC+1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(PAT_CNT-1);
  localparam logic [IDX_W-1:0] MAX_IDX    = IDX_W'(PAT_CNT);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_APPLY,
    S_CAPTURE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_PI-1:0]   r_lfsr;
  logic [MISR_W-1:0]   r_misr;
  logic [CNT_W-1:0]    r_settle;
  logic [NUM_PI-1:0]   r_cut_pi;
  logic [IDX_W-1:0]    r_pat_idx;
  logic                r_pass;
  logic                w_settle_done;
  logic                w_last_pat;
  logic [NUM_PI-1:0]   w_lfsr_nxt;
  logic [MISR_W-1:0]   w_misr_nxt;

  function automatic logic [NUM_PI-1:0] lfsr_step(input logic [NUM_PI-1:0] v);
    return {v[NUM_PI-2:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] v,
                                                  input logic [NUM_PO-1:0] po);
    return {v[MISR_W-2:0], ^(v & MISR_TAPS)} ^ MISR_W'(po);
  endfunction

  function automatic logic [IDX_W-1:0] idx_sat_inc(input logic [IDX_W-1:0] v);
    return (v >= MAX_IDX) ? MAX_IDX : v + 1'b1;
  endfunction

  assign w_settle_done = (r_settle == SETTLE_END);
  assign w_last_pat    = (r_pat_idx == LAST_IDX);
  assign w_lfsr_nxt    = lfsr_step(r_lfsr);
  assign w_misr_nxt    = misr_step(r_misr, cut_po);

  always_ff @(posedge CK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE,
      S_DONE:    if (start) w_state_nxt = S_SEED;
      S_SEED:    w_state_nxt = S_APPLY;
      S_APPLY:   if (w_settle_done) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = w_last_pat ? S_COMPARE : S_APPLY;
      S_COMPARE: w_state_nxt = S_DONE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  // cut_pi is reloaded only on entry to APPLY, so it stays stable through APPLY and CAPTURE
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_lfsr    <= LFSR_SEED;
      r_misr    <= '0;
      r_settle  <= '0;
      r_cut_pi  <= '0;
      r_pat_idx <= '0;
      r_pass    <= 1'b0;
    end else if (abort) begin
      r_lfsr    <= LFSR_SEED;
      r_misr    <= '0;
      r_settle  <= '0;
      r_cut_pi  <= '0;
      r_pat_idx <= '0;
      r_pass    <= 1'b0;
    end else begin
      case (r_state)
        S_SEED: begin
          r_lfsr    <= LFSR_SEED;
          r_misr    <= '0;
          r_settle  <= '0;
          r_pat_idx <= '0;
          r_pass    <= 1'b0;
          r_cut_pi  <= LFSR_SEED;
        end
        S_APPLY: begin
          if (w_settle_done) r_settle <= '0;
          else               r_settle <= r_settle + 1'b1;
        end
        S_CAPTURE: begin
          r_misr    <= w_misr_nxt;
          r_lfsr    <= w_lfsr_nxt;
          r_pat_idx <= idx_sat_inc(r_pat_idx);
          r_cut_pi  <= w_last_pat ? '0 : w_lfsr_nxt;
        end
        S_COMPARE: begin
          r_pass <= (r_misr == GOLDEN_SIG);
        end
        default: begin
          r_cut_pi <= '0;
        end
      endcase
    end
  end

  assign cut_pi  = r_cut_pi;
  assign pat_idx = r_pat_idx;
  assign pass    = r_pass;
  assign done    = (r_state == S_DONE);
  assign busy    = (r_state == S_SEED) || (r_state == S_APPLY) ||
                   (r_state == S_CAPTURE) || (r_state == S_COMPARE);

`ifdef BIST_SIG_OUT_EN
  assign sig = r_misr;
`endif

endmodule
